energy_threshold_tagger: RTL

- Upstream neighbour of the threshold-cutter window stage.
- Takes 32-byte sensor packets and computes accelerometer energy Ax²+Ay²+Az².
- Compares the energy against a runtime-loadable threshold, extended by a hold (hysteresis) counter.
- Emits {packet, flag} with a one-cycle write strobe in the exact format the window stage consumes: packet in bits [WINDOW_WIDTH:1], flag in bit 0.

---
 rtl/energy_threshold_tagger_pkg.sv | 14 +
 rtl/energy_threshold_tagger_if.sv | 23 ++
 rtl/energy_threshold_tagger_signed_square.sv | 28 ++
 rtl/energy_threshold_tagger.sv | 134 +++++++++++++
 4 files changed

// File: rtl/energy_threshold_tagger_pkg.sv
// Shared constants for the accelerometer energy tagger: field layout and datapath widths.
package energy_tagger_pkg;

  localparam int ENERGY_W = 32;
  localparam int SQ_SRC_W = 16;

  // Byte offsets of each accelerometer axis relative to A_OFFSET; high byte first.
  localparam int AZ_IDX = 2;
  localparam int AY_IDX = 4;
  localparam int AX_IDX = 6;

  localparam logic [ENERGY_W-1:0] DEFAULT_THRESHOLD = 32'h0010_0000;

endpackage

// File: rtl/energy_threshold_tagger_if.sv
// Packet-in / tagged-packet-out bus between the sensor source, the tagger and the window stage.
interface energy_threshold_tagger_if #(
  parameter int WINDOW_WIDTH = 256
);
  logic [WINDOW_WIDTH-1:0] pkt_i;
  logic                    pkt_valid;
  logic [WINDOW_WIDTH:0]   data_o;
  logic                    data_wen;

  modport master (
    output pkt_i,
    output pkt_valid,
    input  data_o,
    input  data_wen
  );

  modport slave (
    input  pkt_i,
    input  pkt_valid,
    output data_o,
    output data_wen
  );
endinterface

// File: rtl/energy_threshold_tagger_signed_square.sv
// Purpose: square of a signed 16-bit sample, returned as an unsigned 32-bit value.
// Latency: 1 cycle (registered output).
// Backpressure: none; free-running, a new operand may arrive every cycle.
module signed_square
  import energy_tagger_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SQ_SRC_W-1:0] din,
  output logic [ENERGY_W-1:0]        sq
);

  logic signed [ENERGY_W-1:0] din_ext;
  logic signed [ENERGY_W-1:0] prod;

  // |din| <= 2^15, so the square (<= 2^30) always fits in the low 32 bits.
  assign din_ext = ENERGY_W'(din);
  assign prod    = din_ext * din_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq <= '0;
    end else begin
      sq <= prod;
    end
  end

endmodule

// File: rtl/energy_threshold_tagger.sv
// Purpose: tag 32-byte sensor packets with Ax^2+Ay^2+Az^2 >= threshold, stretched by a hold counter.
// Latency: 3 cycles pkt_valid -> data_wen; optional monitor ports under ENERGY_TAGGER_MONITOR_EN.
// Backpressure: none; accepts a packet every cycle, outputs strobe in order.
module energy_threshold_tagger
  import energy_tagger_pkg::*;
#(
  parameter int                   WINDOW_WIDTH = 256,
  parameter int                   A_OFFSET     = 2,
  parameter logic [ENERGY_W-1:0]  THRESHOLD    = DEFAULT_THRESHOLD,
  parameter int                   HOLD_LEN     = 8,
  parameter int                   HOLD_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  energy_threshold_tagger_if.slave bus,
  input  logic [ENERGY_W-1:0]     thr_i,
  input  logic                    thr_wen,
  output logic [ENERGY_W-1:0]     thr_o
`ifdef ENERGY_TAGGER_MONITOR_EN
  ,
  output logic [ENERGY_W-1:0]     energy_o,
  output logic [ENERGY_W-1:0]     peak_o,
  input  logic                    peak_clr
`endif
);

  localparam int AZ_LSB = 8 * (A_OFFSET + AZ_IDX);
  localparam int AY_LSB = 8 * (A_OFFSET + AY_IDX);
  localparam int AX_LSB = 8 * (A_OFFSET + AX_IDX);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_LEN);

  logic signed [SQ_SRC_W-1:0] az, ay, ax;
  logic [ENERGY_W-1:0]        sq_az, sq_ay, sq_ax;

  logic                       s1_vld;
  logic [WINDOW_WIDTH-1:0]    s1_pkt;
  logic                       s2_vld;
  logic [WINDOW_WIDTH-1:0]    s2_pkt;
  logic [ENERGY_W-1:0]        s2_energy;

  logic [ENERGY_W-1:0]        thr_q;
  logic [HOLD_W-1:0]          hold_cnt;
  logic [HOLD_W-1:0]          hold_nxt;
  logic                       flag;

  // Fields are stored high byte first, so the lower-addressed byte is the MSB.
  assign az = {bus.pkt_i[AZ_LSB +: 8], bus.pkt_i[AZ_LSB+8 +: 8]};
  assign ay = {bus.pkt_i[AY_LSB +: 8], bus.pkt_i[AY_LSB+8 +: 8]};
  assign ax = {bus.pkt_i[AX_LSB +: 8], bus.pkt_i[AX_LSB+8 +: 8]};

  signed_square u_sq_az (.clk(clk), .rst_n(rst_n), .din(az), .sq(sq_az));
  signed_square u_sq_ay (.clk(clk), .rst_n(rst_n), .din(ay), .sq(sq_ay));
  signed_square u_sq_ax (.clk(clk), .rst_n(rst_n), .din(ax), .sq(sq_ax));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pkt <= '0;
    end else begin
      s1_vld <= bus.pkt_valid;
      s1_pkt <= bus.pkt_i;
    end
  end

  // Each square is <= 2^30, so the three-way sum stays below 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_pkt    <= '0;
      s2_energy <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_pkt    <= s1_pkt;
      s2_energy <= sq_az + sq_ay + sq_ax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= THRESHOLD;
    end else if (thr_wen) begin
      thr_q <= thr_i;
    end
  end

  assign thr_o = thr_q;

  always_comb begin
    flag     = 1'b0;
    hold_nxt = hold_cnt;
    if (s2_energy >= thr_q) begin
      flag     = 1'b1;
      hold_nxt = HOLD_INIT;
    end else if (hold_cnt != '0) begin
      flag     = 1'b1;
      hold_nxt = hold_cnt - 1'b1;
    end
  end

  // Hold state only advances on valid packets so idle gaps do not shorten the stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_o   <= '0;
      bus.data_wen <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      bus.data_wen <= s2_vld;
      if (s2_vld) begin
        bus.data_o <= {s2_pkt, flag};
        hold_cnt   <= hold_nxt;
      end
    end
  end

`ifdef ENERGY_TAGGER_MONITOR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_o <= '0;
      peak_o   <= '0;
    end else begin
      if (s2_vld) begin
        energy_o <= s2_energy;
      end
      // A clear that lands on an emitted packet restarts the peak from that packet.
      if (peak_clr) begin
        peak_o <= s2_vld ? s2_energy : '0;
      end else if (s2_vld && (s2_energy > peak_o)) begin
        peak_o <= s2_energy;
      end
    end
  end
`endif

endmodule
